nibble_serial_addsub: RTL

Multi-cycle controller that performs a full-width add or subtract by sequencing a single 4-bit add/sub slice across the operand, one nibble per clock, carrying between nibbles in a register. It serves the area-reduced ALU path. It accepts one operation through a start/busy handshake and returns the result, a one-cycle done pulse and condition flags (V, Z, N, C). An optional saturation stage clamps overflowed results.

---
 rtl/nibble_serial_addsub.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial add/sub: one 4-bit slice reused across the operand, V/Z/N/C flags.
// Optional clamp of overflowed results when SATURATE_ADD_EN is defined.
module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 sub_i,
    input  logic [4*NIBBLES-1:0] a_i,
    input  logic [4*NIBBLES-1:0] b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4*NIBBLES-1:0] result_o,
    output logic                 ovfl_o,
    output logic                 zero_o,
    output logic                 neg_o,
    output logic                 carry_o
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           cin_q, cin_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   res_q, res_d;
    logic           done_q, done_d;
    logic           ovfl_q, ovfl_d;
    logic           zero_q, zero_d;
    logic           neg_q, neg_d;
    logic           carry_q, carry_d;

    logic [3:0]     nib_a;
    logic [3:0]     nib_b;
    logic [4:0]     sum;
    logic [W-1:0]   raw;
    logic [W-1:0]   fin;
    logic           ovfl_c;

    // Single shared 4-bit slice, steered by the nibble index
    always_comb begin
        nib_a = opa_q[{idx_q, 2'b00} +: 4];
        nib_b = opb_q[{idx_q, 2'b00} +: 4];
        sum   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, cin_q};
        raw   = {sum[3:0], res_q[W-5:0]};
        ovfl_c = (~opa_q[W-1] & ~opb_q[W-1] & raw[W-1])
               | ( opa_q[W-1] &  opb_q[W-1] & ~raw[W-1]);
`ifdef SATURATE_ADD_EN
        if (ovfl_c) begin
            fin = opa_q[W-1] ? {1'b1, {(W-1){1'b0}}}
                             : {1'b0, {(W-1){1'b1}}};
        end else begin
            fin = raw;
        end
`else
        fin = raw;
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cin_d   = cin_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        done_d  = 1'b0;
        ovfl_d  = ovfl_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    opa_d   = a_i;
                    opb_d   = sub_i ? ~b_i : b_i;
                    cin_d   = sub_i;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[{idx_q, 2'b00} +: 4] = sum[3:0];
                cin_d = sum[4];
                idx_d = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    // Final nibble: commit (possibly clamped) result and flags
                    idx_d   = '0;
                    res_d   = fin;
                    done_d  = 1'b1;
                    ovfl_d  = ovfl_c;
                    zero_d  = (fin == '0);
                    neg_d   = fin[W-1];
                    carry_d = sum[4];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cin_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cin_q   <= cin_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            done_q  <= done_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
        end
    end

    assign busy_o   = (state_q == RUN);
    assign done_o   = done_q;
    assign result_o = res_q;
    assign ovfl_o   = ovfl_q;
    assign zero_o   = zero_q;
    assign neg_o    = neg_q;
    assign carry_o  = carry_q;

endmodule
